// File: rtl/mos6502_alu.sv
// mos6502_alu: registered 8-bit ALU (ADC, ROR, AND, OR, EOR) with C/V/Z/N flags.
module mos6502_alu (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] alu_control,
  input  logic [7:0] alu_AI,
  input  logic [7:0] alu_BI,
  input  logic       alu_carry_in,
  output logic [7:0] alu_Y,
  output logic       alu_carry_out,
  output logic       alu_overflow,
  output logic       alu_zero,
  output logic       alu_negative
);
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_AND = 3'b001;
  localparam logic [2:0] OP_OR  = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_SR  = 3'b100;
  logic [8:0] sum;
  logic [7:0] y_d, y_q;
  logic       c_d, c_q, v_d, v_q, z_q, n_q;
  always_comb begin
    sum = {1'b0, alu_AI} + {1'b0, alu_BI} + {8'b0, alu_carry_in};
    y_d = 8'h00;
    c_d = 1'b0;
    v_d = 1'b0;
    case (alu_control)
      OP_ADD: begin
        y_d = sum[7:0];
        c_d = sum[8];
        v_d = (alu_AI[7] == alu_BI[7]) && (sum[7] != alu_AI[7]);
      end
      OP_AND: y_d = alu_AI & alu_BI;
      OP_OR:  y_d = alu_AI | alu_BI;
      OP_XOR: y_d = alu_AI ^ alu_BI;
      OP_SR: begin
        y_d = {alu_carry_in, alu_AI[7:1]};
        c_d = alu_AI[0];
      end
      default: y_d = 8'h00;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_q <= 8'h00;
      c_q <= 1'b0;
      v_q <= 1'b0;
      z_q <= 1'b1;
      n_q <= 1'b0;
    end else begin
      y_q <= y_d;
      c_q <= c_d;
      v_q <= v_d;
      z_q <= (y_d == 8'h00);
      n_q <= y_d[7];
    end
  end
  assign alu_Y         = y_q;
  assign alu_carry_out = c_q;
  assign alu_overflow  = v_q;
  assign alu_zero      = z_q;
  assign alu_negative  = n_q;
endmodule

// File: tb/tb_mos6502_alu.sv
// tb_mos6502_alu: directed vector table, reference sweep and reset/latency sequences.
module tb_mos6502_alu;
  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] alu_control;
  logic [7:0] alu_AI, alu_BI;
  logic       alu_carry_in;
  logic [7:0] alu_Y;
  logic       alu_carry_out, alu_overflow, alu_zero, alu_negative;
  int errors = 0;
  int checks = 0;

  mos6502_alu dut (
    .clk(clk), .rst(rst), .alu_control(alu_control), .alu_AI(alu_AI), .alu_BI(alu_BI),
    .alu_carry_in(alu_carry_in), .alu_Y(alu_Y), .alu_carry_out(alu_carry_out),
    .alu_overflow(alu_overflow), .alu_zero(alu_zero), .alu_negative(alu_negative)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] op;
    logic [7:0] a, b;
    logic       cin;
    logic [7:0] y;
    logic       c, v, z, n;
  } vec_t;

  vec_t vecs [19];

  task automatic check(input string name, input logic [7:0] y, input logic c, v, z, n);
    checks++;
    if ({alu_Y, alu_carry_out, alu_overflow, alu_zero, alu_negative} !== {y, c, v, z, n}) begin
      errors++;
      $display("FAIL %s: got Y=%h C=%b V=%b Z=%b N=%b, want Y=%h C=%b V=%b Z=%b N=%b",
               name, alu_Y, alu_carry_out, alu_overflow, alu_zero, alu_negative, y, c, v, z, n);
    end
  endtask

  task automatic drive(input logic [2:0] op, input logic [7:0] a, b, input logic cin);
    alu_control = op; alu_AI = a; alu_BI = b; alu_carry_in = cin;
  endtask

  function automatic logic [10:0] model(input logic [2:0] op, input logic [7:0] a, b, input logic cin);
    int s, ss;
    logic [7:0] y;
    logic c, v;
    y = 8'h00; c = 1'b0; v = 1'b0;
    if (op == 3'd0) begin
      s = int'(a) + int'(b) + int'(cin);
      ss = int'($signed(a)) + int'($signed(b)) + int'(cin);
      y = s[7:0]; c = (s > 255); v = (ss > 127) || (ss < -128);
    end else if (op == 3'd1) y = a & b;
    else if (op == 3'd2) y = a | b;
    else if (op == 3'd3) y = a ^ b;
    else if (op == 3'd4) begin
      y = {cin, a[7:1]}; c = a[0];
    end
    return {y, c, v, y == 8'h00};
  endfunction

  initial begin
    logic [10:0] m;
    vecs[0]  = '{3'd0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[1]  = '{3'd0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[2]  = '{3'd0, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[3]  = '{3'd0, 8'h50, 8'h50, 1'b1, 8'hA1, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[4]  = '{3'd0, 8'h10, 8'h20, 1'b1, 8'h31, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{3'd0, 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[6]  = '{3'd4, 8'h81, 8'h00, 1'b1, 8'hC0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[7]  = '{3'd4, 8'h02, 8'hFF, 1'b0, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{3'd4, 8'h01, 8'h55, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[9]  = '{3'd4, 8'hFE, 8'hFF, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[10] = '{3'd1, 8'hF0, 8'h3C, 1'b0, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{3'd1, 8'h0F, 8'hF0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[12] = '{3'd2, 8'hF0, 8'h0F, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[13] = '{3'd2, 8'h00, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[14] = '{3'd3, 8'hAA, 8'hFF, 1'b0, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[15] = '{3'd3, 8'h5A, 8'h5A, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[16] = '{3'd7, 8'hFF, 8'hFF, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[17] = '{3'd5, 8'h12, 8'h34, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[18] = '{3'd6, 8'h80, 8'h80, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0};

    rst = 1'b1;
    drive(3'd0, 8'h7F, 8'h01, 1'b0);
    #2 check("reset_state", 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk) rst = 1'b0;

    for (int i = 0; i < 19; i++) begin
      @(negedge clk) drive(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cin);
      @(posedge clk) #1;
      check($sformatf("vec%0d", i), vecs[i].y, vecs[i].c, vecs[i].v, vecs[i].z, vecs[i].n);
    end

    for (int op = 0; op < 8; op++)
      for (int a = 0; a < 256; a += 17)
        for (int b = 3; b < 256; b += 23)
          for (int ci = 0; ci < 2; ci++) begin
            @(negedge clk) drive(3'(op), 8'(a), 8'(b), 1'(ci));
            m = model(3'(op), 8'(a), 8'(b), 1'(ci));
            @(posedge clk) #1;
            check($sformatf("sweep op=%0d a=%h b=%h c=%0d", op, a, b, ci), m[10:3], m[2], m[1], m[0], m[10]);
          end

    @(negedge clk) drive(3'd3, 8'hAA, 8'hFF, 1'b0);
    @(posedge clk) #1;
    drive(3'd2, 8'h00, 8'h00, 1'b0);
    #2 check("latency_hold", 8'h55, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk) check("latency_hold_neg", 8'h55, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk) #1 check("latency_update", 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);

    @(negedge clk) drive(3'd0, 8'h7F, 8'h01, 1'b0);
    @(posedge clk) #1 check("pre_reset", 8'h80, 1'b0, 1'b1, 1'b0, 1'b1);
    #2 rst = 1'b1;
    #1 check("async_reset", 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    @(posedge clk) #1 check("reset_holds_edge", 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk) begin
      rst = 1'b0;
      drive(3'd4, 8'h81, 8'h00, 1'b1);
    end
    #1 check("reset_release_wait", 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    @(posedge clk) #1 check("first_after_reset", 8'hC0, 1'b1, 1'b0, 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
